// File: rtl/mole_spawner_pkg.sv
// Shared definitions for the whack-a-mole spawner: state encoding, widths
// and the saturating counter update used by score and miss tallies.
package mole_spawner_pkg;

   localparam int LED_W   = 18;
   localparam int SCORE_W = 16;
   localparam int COUNT_W = 5;
   localparam int TIMER_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      SHOW,
      GAP
   } state_t;

   // Tallies stick at all-ones rather than wrapping back to zero.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] total,
                                                  input logic [COUNT_W-1:0] inc);
      logic [SCORE_W:0] sum;
      sum = {1'b0, total} + {{(SCORE_W + 1 - COUNT_W){1'b0}}, inc};
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/mole_spawner_popcount18.sv
// Combinational population count of an 18-bit mole mask.
module popcount18
   import mole_spawner_pkg::*;
(
   input  logic [LED_W-1:0]   bits,
   output logic [COUNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < LED_W; i++) begin
         count = count + {{(COUNT_W - 1){1'b0}}, bits[i]};
      end
   end

endmodule

// File: rtl/mole_spawner.sv
// Round sequencer for the mole game: requests a random mask from the external
// LFSR, shows it, scores switch hits and tallies expired moles.
module mole_spawner
   import mole_spawner_pkg::*;
#(
   parameter int SHOW_CYCLES = 50000000,
   parameter int GAP_CYCLES  = 12500000,
   parameter int RNG_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [LED_W-1:0]   rng_value,
   output logic               rng_change,
   input  logic [LED_W-1:0]   sw,
   output logic [LED_W-1:0]   leds,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] misses,
   output logic               round_done
);

   localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RNG_LOAD  = TIMER_W'(RNG_LATENCY - 1);

   state_t             state;
   state_t             state_next;
   logic [LED_W-1:0]   mask;
   logic [LED_W-1:0]   sw_prev;
   logic [LED_W-1:0]   hits;
   logic [LED_W-1:0]   mask_left;
   logic [TIMER_W-1:0] timer;
   logic [COUNT_W-1:0] hit_count;
   logic [COUNT_W-1:0] miss_count;
   logic               timer_zero;
   logic               round_end;

   // Only rising switch edges on lit moles count; held switches never re-hit.
   always_comb begin
      hits       = (state == SHOW) ? (sw & ~sw_prev & mask) : '0;
      mask_left  = mask & ~hits;
      timer_zero = (timer == '0);
      round_end  = (state == SHOW) && enable && ((mask_left == '0) || timer_zero);
   end

   popcount18 u_hit_count (
      .bits  (hits),
      .count (hit_count)
   );

   popcount18 u_miss_count (
      .bits  (mask_left),
      .count (miss_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = REQ;
         REQ:     state_next = WAIT;
         WAIT:    if (timer_zero) state_next = SHOW;
         SHOW:    if (round_end) state_next = GAP;
         GAP:     if (timer_zero) state_next = REQ;
         default: state_next = IDLE;
      endcase
      if (!enable) begin
         state_next = IDLE;
      end
   end

   always_comb begin
      rng_change = (state == REQ);
      leds       = (state == SHOW) ? mask : '0;
      round_done = round_end;
   end

   // Shared timer covers RNG latency, show window and dark gap in turn.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask    <= '0;
         sw_prev <= '0;
         timer   <= '0;
         score   <= '0;
         misses  <= '0;
      end else begin
         sw_prev <= sw;
         if (enable) begin
            case (state)
               REQ: timer <= RNG_LOAD;
               WAIT: begin
                  if (timer_zero) begin
                     mask  <= (rng_value == '0) ? {{(LED_W - 1){1'b0}}, 1'b1} : rng_value;
                     timer <= SHOW_LOAD;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               SHOW: begin
                  mask  <= mask_left;
                  score <= sat_add(score, hit_count);
                  if (timer_zero) begin
                     misses <= sat_add(misses, miss_count);
                  end
                  timer <= round_end ? GAP_LOAD : timer - 1'b1;
               end
               GAP: if (!timer_zero) timer <= timer - 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with short show/gap windows.
module tb_mole_spawner;
   import mole_spawner_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic [LED_W-1:0]   rng_value;
   logic               rng_change;
   logic [LED_W-1:0]   sw;
   logic [LED_W-1:0]   leds;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] misses;
   logic               round_done;

   int check_count = 0;
   int error_count = 0;
   int exp_score   = 0;
   int exp_misses  = 0;

   mole_spawner #(
      .SHOW_CYCLES (8),
      .GAP_CYCLES  (2),
      .RNG_LATENCY (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .rng_value  (rng_value),
      .rng_change (rng_change),
      .sw         (sw),
      .leds       (leds),
      .score      (score),
      .misses     (misses),
      .round_done (round_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [LED_W-1:0] rng, input logic [LED_W-1:0] switches);
      enable    = en;
      rng_value = rng;
      sw        = switches;
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 18'h00005, '0);
      tick(2);
      checkOutput("reset_leds", 32'(leds), 0);
      checkOutput("reset_rng_change", 32'(rng_change), 0);
      checkOutput("reset_round_done", 32'(round_done), 0);
      checkOutput("reset_score", 32'(score), 0);
      checkOutput("reset_misses", 32'(misses), 0);

      // First round: single change pulse, mask shown two cycles later
      reset = 1'b0;
      applyStimulus(1'b1, 18'h00005, '0);
      checkOutput("idle_rng_change", 32'(rng_change), 0);
      tick(1);
      checkOutput("req_rng_change", 32'(rng_change), 1);
      checkOutput("req_leds", 32'(leds), 0);
      tick(1);
      checkOutput("wait_rng_change", 32'(rng_change), 0);
      tick(1);
      checkOutput("show_leds_5", 32'(leds), 32'h5);

      // Two simultaneous hits clear the whole mask
      applyStimulus(1'b1, 18'h00005, 18'h00005);
      checkOutput("double_hit_round_done", 32'(round_done), 1);
      tick(1);
      exp_score = sat(exp_score + 2);
      checkOutput("gap_leds", 32'(leds), 0);
      checkOutput("gap_round_done", 32'(round_done), 0);
      checkOutput("double_hit_score", 32'(score), 32'(exp_score));
      checkOutput("double_hit_misses", 32'(misses), 32'(exp_misses));
      applyStimulus(1'b1, 18'h00000, '0);
      tick(1);
      checkOutput("gap2_leds", 32'(leds), 0);
      tick(1);
      checkOutput("after_gap_rng_change", 32'(rng_change), 1);

      // Zero from the generator becomes a single mole
      tick(2);
      checkOutput("zero_rng_leds", 32'(leds), 32'h1);
      tick(6);
      checkOutput("show7_round_done", 32'(round_done), 0);
      checkOutput("show7_leds", 32'(leds), 32'h1);
      tick(1);
      checkOutput("timeout1_round_done", 32'(round_done), 1);
      applyStimulus(1'b1, 18'h00007, '0);
      tick(1);
      exp_misses = sat(exp_misses + 1);
      checkOutput("timeout1_misses", 32'(misses), 32'(exp_misses));
      checkOutput("timeout1_gap_leds", 32'(leds), 0);
      tick(1);
      checkOutput("timeout1_gap2_rng_change", 32'(rng_change), 0);
      tick(1);
      checkOutput("timeout1_next_req", 32'(rng_change), 1);

      // Mask 7: edge on an unlit bit is ignored, last-cycle hit plus timeout
      tick(2);
      checkOutput("show_leds_7", 32'(leds), 32'h7);
      tick(1);
      applyStimulus(1'b1, 18'h00007, 18'h00010);
      tick(1);
      checkOutput("unlit_edge_score", 32'(score), 32'(exp_score));
      checkOutput("unlit_edge_leds", 32'(leds), 32'h7);
      tick(4);
      checkOutput("mask7_show7_round_done", 32'(round_done), 0);
      tick(1);
      applyStimulus(1'b1, 18'h00003, 18'h00012);
      checkOutput("hit_and_timeout_round_done", 32'(round_done), 1);
      checkOutput("hit_and_timeout_leds", 32'(leds), 32'h7);
      tick(1);
      exp_score  = sat(exp_score + 1);
      exp_misses = sat(exp_misses + 2);
      checkOutput("hit_and_timeout_score", 32'(score), 32'(exp_score));
      checkOutput("hit_and_timeout_misses", 32'(misses), 32'(exp_misses));
      checkOutput("hit_and_timeout_round_done_low", 32'(round_done), 0);
      checkOutput("hit_and_timeout_gap_leds", 32'(leds), 0);

      // Dropping enable mid-show abandons the round silently
      applyStimulus(1'b1, 18'h00003, '0);
      tick(4);
      checkOutput("show_leds_3", 32'(leds), 32'h3);
      applyStimulus(1'b0, 18'h00003, '0);
      checkOutput("disable_round_done", 32'(round_done), 0);
      tick(1);
      checkOutput("disable_leds", 32'(leds), 0);
      checkOutput("disable_misses", 32'(misses), 32'(exp_misses));
      checkOutput("disable_score", 32'(score), 32'(exp_score));
      tick(1);
      checkOutput("disable_idle_rng_change", 32'(rng_change), 0);

      // Reset in the middle of a show clears everything at once
      applyStimulus(1'b1, 18'h00003, '0);
      tick(3);
      checkOutput("pre_reset_leds", 32'(leds), 32'h3);
      reset = 1'b1;
      #1;
      checkOutput("midreset_leds", 32'(leds), 0);
      checkOutput("midreset_score", 32'(score), 0);
      checkOutput("midreset_misses", 32'(misses), 0);
      checkOutput("midreset_rng_change", 32'(rng_change), 0);
      checkOutput("midreset_round_done", 32'(round_done), 0);
      tick(2);
      reset      = 1'b0;
      exp_score  = 0;
      exp_misses = 0;

      // A switch held high into the show window must not score
      applyStimulus(1'b1, 18'h00001, 18'h00001);
      tick(3);
      checkOutput("held_sw_leds", 32'(leds), 32'h1);
      tick(1);
      checkOutput("held_sw_leds_kept", 32'(leds), 32'h1);
      checkOutput("held_sw_score", 32'(score), 32'(exp_score));
      applyStimulus(1'b0, 18'h00001, '0);
      tick(1);

      // Full-mask rounds drive the score into saturation
      applyStimulus(1'b1, 18'h3FFFF, '0);
      tick(1);
      checkOutput("sat_first_req", 32'(rng_change), 1);
      for (int r = 0; r < 3642; r++) begin
         tick(2);
         applyStimulus(1'b1, 18'h3FFFF, 18'h3FFFF);
         tick(1);
         exp_score = sat(exp_score + 18);
         applyStimulus(1'b1, 18'h3FFFF, '0);
         if (r == 3639) begin
            checkOutput("score_before_sat", 32'(score), 32'(exp_score));
         end
         tick(2);
      end
      checkOutput("score_saturated", 32'(score), 32'hFFFF);
      checkOutput("score_model_sat", 32'(score), 32'(exp_score));
      checkOutput("sat_misses", 32'(misses), 32'(exp_misses));

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
